// File: rtl/csr_file_if.sv
// Bus between the execute stage and the machine-mode CSR responder.
// The core drives the instruction fields. The CSR file returns the old value and the illegal flag.
interface csr_file_if #(
  parameter int XLEN = 32
);
  logic            Csr;
  logic [2:0]      funct3;
  logic [11:0]     csr_addr;
  logic [4:0]      rs1_idx;
  logic [XLEN-1:0] rs1_data;
  logic [4:0]      rd_idx;
  logic            instr_retire;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output Csr, funct3, csr_addr, rs1_idx, rs1_data, rd_idx, instr_retire,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  Csr, funct3, csr_addr, rs1_idx, rs1_data, rd_idx, instr_retire,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for the single-cycle core. It reads combinationally and does the read-modify-write on the clock edge.
// It also owns the 64-bit mcycle and minstret counters and their read-only user shadows.
module csr_file #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
  parameter bit              HAS_COUNTERS = 1'b1
) (
  input logic       clk,
  input logic       reset,
  csr_file_if.slave bus
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  localparam logic [XLEN-1:0] MSTATUS_MASK = XLEN'(32'h0000_0088);
  localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(3);

  logic [XLEN-1:0] mstatus, mtvec, mscratch, mepc, mcause;
  logic [63:0]     mcycle, minstret;

  logic            addr_ok, f3_ok, ro, wen_raw, wen;
  logic [XLEN-1:0] old, src, nv;
  logic            wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
  logic            unused_rd;

  // rd_idx plays no part in the CSR decision: RW/RWI write even when rd is x0.
  assign unused_rd = ^bus.rd_idx;

  always_comb begin
    addr_ok = 1'b1;
    old     = '0;
    case (bus.csr_addr)
      A_MSTATUS:                old = mstatus;
      A_MTVEC:                  old = mtvec;
      A_MSCRATCH:               old = mscratch;
      A_MEPC:                   old = mepc;
      A_MCAUSE:                 old = mcause;
      A_MCYCLE,   A_CYCLE:      old = XLEN'(mcycle[31:0]);
      A_MCYCLEH,  A_CYCLEH:     old = XLEN'(mcycle[63:32]);
      A_MINSTRET, A_INSTRET:    old = XLEN'(minstret[31:0]);
      A_MINSTRETH, A_INSTRETH:  old = XLEN'(minstret[63:32]);
      default:                  addr_ok = 1'b0;
    endcase
  end

  always_comb begin
    f3_ok   = (bus.funct3[1:0] != 2'b00);
    ro      = (bus.csr_addr[11:10] == 2'b11);
    // A set or clear with a zero operand index is a pure read. It never counts as a write, even to a read-only CSR.
    wen_raw = bus.Csr & addr_ok & f3_ok &
              ((bus.funct3[1:0] == 2'b01) | (bus.rs1_idx != 5'd0));
    wen     = wen_raw & ~ro;
    src     = bus.funct3[2] ? XLEN'(bus.rs1_idx) : bus.rs1_data;
    case (bus.funct3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    wr_cyc_lo = wen & (bus.csr_addr == A_MCYCLE);
    wr_cyc_hi = wen & (bus.csr_addr == A_MCYCLEH);
    wr_ins_lo = wen & (bus.csr_addr == A_MINSTRET);
    wr_ins_hi = wen & (bus.csr_addr == A_MINSTRETH);
  end

  assign bus.csr_rdata   = (bus.Csr & addr_ok) ? old : '0;
  assign bus.csr_illegal = bus.Csr & (~addr_ok | ~f3_ok | (ro & wen_raw));

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus  <= '0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else if (wen) begin
      case (bus.csr_addr)
        A_MSTATUS:  mstatus  <= nv & MSTATUS_MASK;
        A_MTVEC:    mtvec    <= nv & ALIGN_MASK;
        A_MSCRATCH: mscratch <= nv;
        A_MEPC:     mepc     <= nv & ALIGN_MASK;
        A_MCAUSE:   mcause   <= nv;
        default:    ;
      endcase
    end
  end

  // A write to either half takes the place of this cycle's increment. A low-half write never carries into the high half.
  always_ff @(posedge clk) begin
    if (reset || !HAS_COUNTERS) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr_cyc_lo)      mcycle[31:0]  <= 32'(nv);
      else if (wr_cyc_hi) mcycle[63:32] <= 32'(nv);
      else                mcycle        <= mcycle + 64'd1;

      if (wr_ins_lo)      minstret[31:0]  <= 32'(nv);
      else if (wr_ins_hi) minstret[63:32] <= 32'(nv);
      else                minstret        <= minstret + 64'(bus.instr_retire);
    end
  end

endmodule
